// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_ctrl: frame-synchronous load handshake plus segment/digit pins.
// The master (status logic) drives data and load_req; the slave (scan controller) drives the rest.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load_req;
  logic                    load_ack;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_tick;

  modport master (
    output value, blank, dp, load_req,
    input  load_ack, seg, dig_sel, frame_tick
  );

  modport slave (
    input  value, blank, dp, load_req,
    output load_ack, seg, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with dead time and frame-boundary loading.
// Optional leading-zero suppression is enabled by defining SEG_LZS_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int DEAD_CYC   = 500
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan_if.slave   bus
);
  localparam int MAXC = (CLK_DIV > DEAD_CYC) ? CLK_DIV : DEAD_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam int IW   = $clog2(NUM_DIGITS);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_value, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_d;
  logic                    boundary;

  logic [7:0]              seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_d;
  logic [NUM_DIGITS-1:0]   sup;
  logic [3:0]              nib;

  function automatic logic [6:0] encode(input logic [3:0] n);
    case (n)
      4'h0: encode = 7'h40;  4'h1: encode = 7'h79;
      4'h2: encode = 7'h24;  4'h3: encode = 7'h30;
      4'h4: encode = 7'h19;  4'h5: encode = 7'h12;
      4'h6: encode = 7'h02;  4'h7: encode = 7'h78;
      4'h8: encode = 7'h00;  4'h9: encode = 7'h10;
      4'hA: encode = 7'h08;  4'hB: encode = 7'h03;
      4'hC: encode = 7'h46;  4'hD: encode = 7'h21;
      4'hE: encode = 7'h06;  default: encode = 7'h0E;
    endcase
  endfunction

  // State register. Outputs are registered from the next-state values so
  // seg/dig_sel line up with state/idx without an extra cycle of lag.
  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the shadow copy, is reset so no stale capture survives a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BLANK;
      cnt            <= '0;
      idx            <= IW'(NUM_DIGITS - 1);
      sh_value       <= '0;
      sh_blank       <= '1;
      sh_dp          <= '0;
      bus.seg        <= 8'hFF;
      bus.dig_sel    <= '1;
      bus.load_ack   <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      idx            <= idx_d;
      sh_value       <= sh_value_d;
      sh_blank       <= sh_blank_d;
      sh_dp          <= sh_dp_d;
      bus.seg        <= seg_d;
      bus.dig_sel    <= dig_sel_d;
      bus.load_ack   <= boundary && bus.load_req;
      bus.frame_tick <= boundary;
    end
  end

  // Next-state logic: phase timer, digit index and frame-boundary capture.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 1'b1;
    idx_d      = idx;
    boundary   = 1'b0;
    sh_value_d = sh_value;
    sh_blank_d = sh_blank;
    sh_dp_d    = sh_dp;
    case (state)
      DRIVE: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt == CW'(DEAD_CYC - 1)) begin
          state_d  = DRIVE;
          cnt_d    = '0;
          boundary = (idx == IW'(NUM_DIGITS - 1));
          idx_d    = boundary ? '0 : idx + 1'b1;
        end
      end
    endcase
    if (boundary && bus.load_req) begin
      sh_value_d = bus.value;
      sh_blank_d = bus.blank;
      sh_dp_d    = bus.dp;
    end
  end

  // Leading-zero mask, derived from the shadow contents that will be displayed.
  always_comb begin
    sup = '0;
`ifdef SEG_LZS_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        lead   = lead && (sh_value_d[4*i +: 4] == 4'h0);
        sup[i] = lead;
      end
    end
`endif
  end

  // Output decode for the upcoming cycle.
  always_comb begin
    seg_d     = 8'hFF;
    dig_sel_d = '1;
    nib       = sh_value_d[{idx_d, 2'b00} +: 4];
    if (state_d == DRIVE) begin
      dig_sel_d[idx_d] = 1'b0;
      if (!sh_blank_d[idx_d] && !sup[idx_d])
        seg_d = {~sh_dp_d[idx_d], encode(nib)};
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, CLK_DIV=4, DEAD_CYC=2, 24-cycle frame).
// Expected outputs come from a cycle-position model of the scan schedule and a shadow-data model.
module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int CD    = 4;
  localparam int DC    = 2;
  localparam int SLOT  = CD + DC;
  localparam int FRAME = N * SLOT;
  localparam logic [7:0] ENC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic clk = 1'b0;
  logic reset;
  seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t;
  logic [4*N-1:0] m_value;
  logic [N-1:0]   m_blank, m_dp;
  logic           e_tick, e_ack;
  logic [13:0]    got, want;

  function automatic bit suppressed(int d);
`ifdef SEG_LZS_EN
    return (d > 0) && ((m_value >> (4 * d)) == 0);
`else
    return (d < 0);
`endif
  endfunction

  // {seg, dig_sel, frame_tick, load_ack} expected in cycle t.
  function automatic logic [13:0] expected();
    logic [7:0] s;
    logic [3:0] d;
    int q, di;
    s = 8'hFF;
    d = 4'hF;
    if (t >= DC) begin
      q  = (t - DC) % FRAME;
      di = q / SLOT;
      if (q % SLOT < CD) begin
        d = ~(4'b0001 << di);
        if (!m_blank[di] && !suppressed(di))
          s = {~m_dp[di], ENC[m_value[di*4 +: 4]][6:0]};
      end
    end
    return {s, d, e_tick, e_ack};
  endfunction

  // Advances one clock; the model sees the inputs the DUT samples on that edge.
  task automatic advance();
    bit bnd;
    bnd    = (t + 1 >= DC) && ((t + 1 - DC) % FRAME == 0);
    e_tick = bnd;
    e_ack  = bnd && bus.load_req;
    if (e_ack) begin
      m_value = bus.value;
      m_blank = bus.blank;
      m_dp    = bus.dp;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset   = 1'b0;
    t       = 0;
    m_value = '0;
    m_blank = '1;
    m_dp    = '0;
    e_tick  = 1'b0;
    e_ack   = 1'b0;
  endtask

  task automatic set_data(logic [15:0] v, logic [3:0] b, logic [3:0] p);
    bus.value = v;
    bus.blank = b;
    bus.dp    = p;
  endtask

  task automatic test_reset();
    bus.load_req = 1'b0;
    set_data(16'h1234, 4'h0, 4'h0);
    do_reset();
    n_checks++;
    if ({bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack} !== {8'hFF, 4'hF, 1'b0, 1'b0})
      $display("FAIL reset_state: got seg=%h dig=%h tick=%b ack=%b, want FF F 0 0",
               bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack);
    else n_pass++;
    while (t < FRAME + DC) begin
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL idle_frame t=%0d: got %h want %h", t, got, want);
      else n_pass++;
      if (t == 2) begin
        n_checks++;
        if (bus.frame_tick !== 1'b1) $display("FAIL first_tick: got %b want 1", bus.frame_tick);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load();
    set_data(16'h12AF, 4'h0, 4'b0100);
    bus.load_req = 1'b1;
    do_reset();
    while (t < 10) begin
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL load t=%0d: got %h want %h", t, got, want);
      else n_pass++;
      if (t == 2) begin
        n_checks++;
        if (got !== {8'h8E, 4'hE, 1'b1, 1'b1}) $display("FAIL load_first_digit: got %h want 8EE3", got);
        else n_pass++;
      end
      if (t == 8) begin
        n_checks++;
        if ({bus.seg, bus.dig_sel} !== {8'h88, 4'hD}) $display("FAIL load_digit1: got %h%h want 88D", bus.seg, bus.dig_sel);
        else n_pass++;
      end
      if (bus.load_ack) bus.load_req = 1'b0;
    end
  endtask

  task automatic test_midframe();
    set_data(16'h0005, 4'h0, 4'h0);
    bus.load_req = 1'b1;
    while (t < 32) begin
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL midframe t=%0d: got %h want %h", t, got, want);
      else n_pass++;
      if (t == 14 || t == 20) begin
        n_checks++;
        if (bus.seg !== ((t == 14) ? 8'h24 : 8'hF9)) $display("FAIL old_value t=%0d: got %h", t, bus.seg);
        else n_pass++;
      end
      if (t == 26) begin
        n_checks++;
        if (got !== {8'h92, 4'hE, 1'b1, 1'b1}) $display("FAIL midframe_ack: got %h want 92E3", got);
        else n_pass++;
      end
      if (bus.load_ack) bus.load_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    set_data(16'hBEEF, 4'h0, 4'h0);
    bus.load_req = 1'b1;
    do_reset();
    while (t < 15) begin
      advance();
      if (bus.load_ack) bus.load_req = 1'b0;
    end
    set_data(16'h4321, 4'h0, 4'hF);
    bus.load_req = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack} !== {8'hFF, 4'hF, 1'b0, 1'b0})
      $display("FAIL reset_mid: got seg=%h dig=%h tick=%b ack=%b, want FF F 0 0",
               bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack);
    else n_pass++;
    bus.load_req = 1'b0;
    do_reset();
    while (t < FRAME + DC) begin
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL after_reset t=%0d: got %h want %h", t, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_blank();
    set_data(16'h8888, 4'b1010, 4'h0);
    bus.load_req = 1'b1;
    do_reset();
    while (t < FRAME + DC) begin
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL blank t=%0d: got %h want %h", t, got, want);
      else n_pass++;
      if (t == 8) begin
        n_checks++;
        if ({bus.seg, bus.dig_sel} !== {8'hFF, 4'hD}) $display("FAIL blank_digit1: got %h%h want FFD", bus.seg, bus.dig_sel);
        else n_pass++;
      end
      if (bus.load_ack) bus.load_req = 1'b0;
    end
  endtask

  task automatic test_lzs();
    set_data(16'h0070, 4'h0, 4'hF);
    bus.load_req = 1'b1;
    do_reset();
    while (t < 2 * FRAME + DC) begin
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL lzs t=%0d: got %h want %h", t, got, want);
      else n_pass++;
      if (bus.load_ack) begin
        bus.load_req = 1'b0;
        if (t < FRAME) begin
          set_data(16'h0000, 4'h0, 4'h0);
          bus.load_req = 1'b1;
        end
      end
    end
  endtask

  task automatic test_random();
    bus.load_req = 1'b0;
    do_reset();
    while (t < 8 * FRAME) begin
      if (!bus.load_req && $urandom_range(0, 5) == 0) begin
        set_data(16'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), 4'($urandom));
        bus.load_req = 1'b1;
      end
      advance();
      got = {bus.seg, bus.dig_sel, bus.frame_tick, bus.load_ack};
      want = expected();
      n_checks++;
      if (got !== want) $display("FAIL random t=%0d: got %h want %h", t, got, want);
      else n_pass++;
      if (bus.load_ack) bus.load_req = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.load_req = 1'b0;
    set_data(16'h0, 4'h0, 4'h0);
    test_reset();
    test_load();
    test_midframe();
    test_reset_mid();
    test_blank();
    test_lzs();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
